// File: rtl/video_pattern_gen_if.sv
// Pattern-generator control and video output bundle.
// master = the generator (drives sync/de/rgb), slave = the downstream sink.
interface video_pattern_gen_if #(
    parameter int COLOR_W = 8
);
    logic [1:0]           mode;
    logic [3*COLOR_W-1:0] solid_rgb;
    logic                 hs;
    logic                 vs;
    logic                 de;
    logic [COLOR_W-1:0]   rgb_r;
    logic [COLOR_W-1:0]   rgb_g;
    logic [COLOR_W-1:0]   rgb_b;
    logic                 frame_start;

    modport master (
        input  mode, solid_rgb,
        output hs, vs, de, rgb_r, rgb_g, rgb_b, frame_start
    );

    modport slave (
        output mode, solid_rgb,
        input  hs, vs, de, rgb_r, rgb_g, rgb_b, frame_start
    );
endinterface

// File: rtl/video_pattern_gen.sv
// Parametrised video timing + test-pattern generator (colour bar, grid,
// ramp, solid). All outputs registered one cycle behind the h/v counters.
module video_pattern_gen #(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 110,
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 220,
    parameter int V_ACTIVE  = 720,
    parameter int V_FP      = 5,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 20,
    parameter int HS_POL    = 1,
    parameter int VS_POL    = 1,
    parameter int COLOR_W   = 8,
    parameter int GRID_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst,
    video_pattern_gen_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int PW      = 3 * COLOR_W;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HW-1:0] H_GMASK  = HW'((1 << GRID_LOG2) - 1);
    localparam logic [VW-1:0] V_GMASK  = VW'((1 << GRID_LOG2) - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
    localparam logic          HS_ON    = 1'(HS_POL);
    localparam logic          VS_ON    = 1'(VS_POL);

    logic [HW-1:0]      h_cnt;
    logic [VW-1:0]      v_cnt;
    logic [BW-1:0]      bar_cnt;
    logic [2:0]         bar_idx;
    logic [1:0]         mode_q;
    logic [PW-1:0]      solid_q;
    logic               at_origin;
    logic [1:0]         mode_eff;
    logic [PW-1:0]      solid_eff;
    logic               de_nxt;
    logic [PW-1:0]      pix;
    logic               hs_q, vs_q, de_q, fs_q;
    logic [PW-1:0]      rgb_q;

    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    // Settings sampled at (0,0) already apply to pixel (0,0) itself.
    assign mode_eff  = at_origin ? vif.mode      : mode_q;
    assign solid_eff = at_origin ? vif.solid_rgb : solid_q;
    assign de_nxt    = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    // Raster counters plus bar-index counter tracking the current h_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt   <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            v_cnt   <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
            if (bar_cnt == BAR_LAST) begin
                bar_cnt <= '0;
                if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + BW'(1);
            end
        end
    end

    // Frame-level capture of pattern settings so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= '0;
            solid_q <= '0;
        end else if (at_origin) begin
            mode_q  <= vif.mode;
            solid_q <= vif.solid_rgb;
        end
    end

    // Pattern colour for the current counter position. The bar order maps
    // directly onto index bits: r=~idx[1], g=~idx[2], b=~idx[0].
    always_comb begin
        pix = '0;
        case (mode_eff)
            2'd0: pix = {{COLOR_W{~bar_idx[1]}}, {COLOR_W{~bar_idx[2]}},
                         {COLOR_W{~bar_idx[0]}}};
            2'd1: if (((h_cnt & H_GMASK) == '0) || ((v_cnt & V_GMASK) == '0))
                      pix = '1;
            2'd2: pix = {3{COLOR_W'(h_cnt)}};
            default: pix = solid_eff;
        endcase
    end

    // Registered output stage; blanking forces rgb to black.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q  <= ~HS_ON;
            vs_q  <= ~VS_ON;
            de_q  <= 1'b0;
            rgb_q <= '0;
            fs_q  <= 1'b0;
        end else begin
            hs_q  <= (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_ON : ~HS_ON;
            vs_q  <= (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_ON : ~VS_ON;
            de_q  <= de_nxt;
            rgb_q <= de_nxt ? pix : '0;
            fs_q  <= at_origin;
        end
    end

    assign vif.hs          = hs_q;
    assign vif.vs          = vs_q;
    assign vif.de          = de_q;
    assign vif.rgb_r       = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign vif.rgb_g       = rgb_q[2*COLOR_W-1:COLOR_W];
    assign vif.rgb_b       = rgb_q[COLOR_W-1:0];
    assign vif.frame_start = fs_q;
endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench: two generators on a 22x7 raster. Instance A (positive
// polarity) walks colour bar, ramp and solid frames plus a mid-frame reset;
// instance B (negative polarity, 4-pixel grid) runs grid throughout.
module tb_video_pattern_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    video_pattern_gen_if #(.COLOR_W(8)) ifa ();
    video_pattern_gen_if #(.COLOR_W(8)) ifb ();

    video_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .COLOR_W(8), .GRID_LOG2(4)
    ) dut_a (.clk(clk), .rst(rst), .vif(ifa));

    video_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .COLOR_W(8), .GRID_LOG2(2)
    ) dut_b (.clk(clk), .rst(rst), .vif(ifb));

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check both instances for raster position n of a frame; fmode is the
    // pattern instance A should be showing.
    task automatic pix_chk(input int n, input int fmode);
        int x, y;
        logic de_e;
        logic [23:0] rgb_a, rgb_b;
        logic [7:0] x8;
        x = n % 22;
        y = n / 22;
        x8 = 8'(x);
        de_e = (x < 16) && (y < 4);
        rgb_a = 24'h0;
        rgb_b = 24'h0;
        if (de_e) begin
            case (fmode)
                0: rgb_a = bars[x/2];
                2: rgb_a = {x8, x8, x8};
                default: rgb_a = 24'h123456;
            endcase
            if ((x % 4 == 0) || (y % 4 == 0)) rgb_b = 24'hFFFFFF;
        end
        chk($sformatf("A.de x%0d y%0d", x, y), 32'(ifa.de), 32'(de_e));
        chk($sformatf("A.hs x%0d y%0d", x, y), 32'(ifa.hs), 32'(x == 18 || x == 19));
        chk($sformatf("A.vs x%0d y%0d", x, y), 32'(ifa.vs), 32'(y == 5));
        chk($sformatf("A.fs x%0d y%0d", x, y), 32'(ifa.frame_start), 32'(n == 0));
        chk($sformatf("A.rgb x%0d y%0d", x, y),
            32'({ifa.rgb_r, ifa.rgb_g, ifa.rgb_b}), 32'(rgb_a));
        chk($sformatf("B.de x%0d y%0d", x, y), 32'(ifb.de), 32'(de_e));
        chk($sformatf("B.hs x%0d y%0d", x, y), 32'(ifb.hs), 32'(!(x == 18 || x == 19)));
        chk($sformatf("B.vs x%0d y%0d", x, y), 32'(ifb.vs), 32'(y != 5));
        chk($sformatf("B.fs x%0d y%0d", x, y), 32'(ifb.frame_start), 32'(n == 0));
        chk($sformatf("B.rgb x%0d y%0d", x, y),
            32'({ifb.rgb_r, ifb.rgb_g, ifb.rgb_b}), 32'(rgb_b));
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, " A.hs"},  32'(ifa.hs), 32'd0);
        chk({tag, " A.vs"},  32'(ifa.vs), 32'd0);
        chk({tag, " A.de"},  32'(ifa.de), 32'd0);
        chk({tag, " A.fs"},  32'(ifa.frame_start), 32'd0);
        chk({tag, " A.rgb"}, 32'({ifa.rgb_r, ifa.rgb_g, ifa.rgb_b}), 32'd0);
        chk({tag, " B.hs"},  32'(ifb.hs), 32'd1);
        chk({tag, " B.vs"},  32'(ifb.vs), 32'd1);
        chk({tag, " B.de"},  32'(ifb.de), 32'd0);
        chk({tag, " B.rgb"}, 32'({ifb.rgb_r, ifb.rgb_g, ifb.rgb_b}), 32'd0);
    endtask

    initial begin
        ifa.mode      = 2'd0;
        ifa.solid_rgb = 24'h0;
        ifb.mode      = 2'd1;
        ifb.solid_rgb = 24'hABCDEF;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_chk("por");
        rst = 1'b0;

        // Frame 0: colour bars; switching to ramp mid-frame must not tear.
        for (int n = 0; n < 154; n++) begin
            @(posedge clk);
            @(negedge clk);
            pix_chk(n, 0);
            if (n == 50) ifa.mode = 2'd2;
        end

        // Frame 1: ramp; solid requested at pixel (5,2) applies next frame.
        for (int n = 0; n < 154; n++) begin
            @(posedge clk);
            @(negedge clk);
            pix_chk(n, 2);
            if (n == 49) begin
                ifa.mode      = 2'd3;
                ifa.solid_rgb = 24'h123456;
            end
        end

        // Frame 2: solid until a one-cycle reset mid line 2.
        for (int n = 0; n < 52; n++) begin
            @(posedge clk);
            @(negedge clk);
            pix_chk(n, 3);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_chk("mid");
        rst = 1'b0;

        // Restarted frame: pixel (0,0) with frame_start right away.
        for (int n = 0; n < 154; n++) begin
            @(posedge clk);
            @(negedge clk);
            pix_chk(n, 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
